// File: rtl/nx_node_decoder_pkg.sv
// Shared message layout, command/parameter encodings and chunk widths for the node decoder.
package nx_node_decoder_pkg;

    localparam int unsigned LOAD_CHUNK_W     = 16;
    localparam int unsigned MASK_CHUNK_W     = 8;
    localparam int unsigned NODE_PARAM_WIDTH = 16;

    typedef enum logic [1:0] {
        CMD_LOAD    = 2'd0,
        CMD_SIGNAL  = 2'd1,
        CMD_CONTROL = 2'd2,
        CMD_RSVD    = 2'd3
    } node_command_t;

    typedef enum logic [2:0] {
        PARAM_NUM_INSTR  = 3'd0,
        PARAM_LOOPBACK   = 3'd1,
        PARAM_LOAD_RESET = 3'd2
    } node_param_t;

    typedef struct packed {
        logic [2:0]              pad;
        logic [LOAD_CHUNK_W-1:0] data;
    } node_load_t;

    typedef struct packed {
        logic [8:0] pad;
        logic [7:0] index;
        logic       is_seq;
        logic       value;
    } node_signal_t;

    typedef struct packed {
        logic [2:0]  param;
        logic [15:0] value;
    } node_control_t;

    typedef union packed {
        node_load_t    load;
        node_signal_t  sig;
        node_control_t ctrl;
    } node_payload_t;

    typedef struct packed {
        node_command_t command;
    } node_header_t;

    typedef struct packed {
        node_header_t  header;
        node_payload_t payload;
    } node_message_t;

endpackage

// File: rtl/nx_node_decoder_load.sv
// LOAD path: pairs 16-bit chunks into instruction words and runs the store write handshake.
module nx_node_decoder_load
    import nx_node_decoder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_W = 10,
    parameter int unsigned RAM_DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic [LOAD_CHUNK_W-1:0] load_data,
    input  logic                    load_reset,
    input  logic                    ram_wr_ready,
    output logic                    wr_pending,
    output logic                    ram_wr_en,
    output logic [RAM_ADDR_W-1:0]   ram_addr,
    output logic [RAM_DATA_W-1:0]   ram_wr_data
);

    logic [LOAD_CHUNK_W-1:0] low_q;
    logic                    half_valid;
    logic [RAM_ADDR_W-1:0]   load_ptr;
    logic [RAM_DATA_W-1:0]   wr_data_q;

    // New messages are refused while a write is pending, so the write
    // completion and a new LOAD/LOAD_RESET never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_q      <= '0;
            half_valid <= 1'b0;
            load_ptr   <= '0;
            wr_data_q  <= '0;
            wr_pending <= 1'b0;
        end else begin
            if (wr_pending && ram_wr_ready) begin
                wr_pending <= 1'b0;
                load_ptr   <= load_ptr + 1'b1;
            end
            if (load_reset) begin
                load_ptr   <= '0;
                half_valid <= 1'b0;
            end else if (load_valid) begin
                if (!half_valid) begin
                    low_q      <= load_data;
                    half_valid <= 1'b1;
                end else begin
                    wr_data_q  <= {load_data, low_q};
                    wr_pending <= 1'b1;
                    half_valid <= 1'b0;
                end
            end
        end
    end

    assign ram_wr_en   = wr_pending;
    assign ram_addr    = load_ptr;
    assign ram_wr_data = wr_data_q;

endmodule

// File: rtl/nx_node_decoder.sv
// Inbound message decoder for a logic node: LOAD to the store, SIGNAL/CONTROL to node control.
// Optional drop statistics counter enabled by defining NX_NODE_DECODER_STATS_EN.
module nx_node_decoder
    import nx_node_decoder_pkg::*;
#(
    parameter int unsigned INPUTS     = 32,
    parameter int unsigned RAM_ADDR_W = 10,
    parameter int unsigned RAM_DATA_W = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  node_message_t               i_msg_data,
    input  logic                        i_msg_valid,
    output logic                        o_msg_ready,
    output logic                        o_idle,
    output logic [RAM_ADDR_W-1:0]       o_ram_addr,
    output logic [RAM_DATA_W-1:0]       o_ram_wr_data,
    output logic                        o_ram_wr_en,
    input  logic                        i_ram_wr_ready,
    output logic [INPUTS-1:0]           o_loopback_mask,
    output logic [$clog2(INPUTS)-1:0]   o_input_index,
    output logic                        o_input_value,
    output logic                        o_input_is_seq,
    output logic                        o_input_update,
    output logic [NODE_PARAM_WIDTH-1:0] o_num_instr,
    output logic [15:0]                 o_drop_count
);

    localparam int unsigned IDX_W = $clog2(INPUTS);

    node_command_t cmd;
    node_signal_t  sig;
    node_control_t ctrl;
    logic          accept;
    logic          sig_ok;
    logic          wr_pending;

    assign cmd    = i_msg_data.header.command;
    assign sig    = i_msg_data.payload.sig;
    assign ctrl   = i_msg_data.payload.ctrl;
    assign accept = i_msg_valid && o_msg_ready;
    assign sig_ok = 32'(sig.index) < INPUTS;

    assign o_msg_ready = i_rst_n && !wr_pending;
    assign o_idle      = i_rst_n && !wr_pending && !i_msg_valid;

    nx_node_decoder_load #(
        .RAM_ADDR_W (RAM_ADDR_W),
        .RAM_DATA_W (RAM_DATA_W)
    ) u_load (
        .clk          (i_clk),
        .rst_n        (i_rst_n),
        .load_valid   (accept && (cmd == CMD_LOAD)),
        .load_data    (i_msg_data.payload.load.data),
        .load_reset   (accept && (cmd == CMD_CONTROL) && (ctrl.param == PARAM_LOAD_RESET)),
        .ram_wr_ready (i_ram_wr_ready),
        .wr_pending   (wr_pending),
        .ram_wr_en    (o_ram_wr_en),
        .ram_addr     (o_ram_addr),
        .ram_wr_data  (o_ram_wr_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_loopback_mask <= '0;
            o_input_index   <= '0;
            o_input_value   <= 1'b0;
            o_input_is_seq  <= 1'b0;
            o_input_update  <= 1'b0;
            o_num_instr     <= '0;
        end else begin
            o_input_update <= 1'b0;
            if (accept) begin
                case (cmd)
                    CMD_SIGNAL: begin
                        if (sig_ok) begin
                            o_input_index  <= sig.index[IDX_W-1:0];
                            o_input_value  <= sig.value;
                            o_input_is_seq <= sig.is_seq;
                            o_input_update <= 1'b1;
                        end
                    end
                    CMD_CONTROL: begin
                        if (ctrl.param == PARAM_NUM_INSTR)
                            o_num_instr <= ctrl.value[NODE_PARAM_WIDTH-1:0];
                        // Matching the select against each chunk also rejects out-of-range selects.
                        if (ctrl.param == PARAM_LOOPBACK) begin
                            for (int unsigned c = 0; c < INPUTS / MASK_CHUNK_W; c++) begin
                                if (ctrl.value[15:8] == 8'(c))
                                    o_loopback_mask[c*MASK_CHUNK_W +: MASK_CHUNK_W] <= ctrl.value[7:0];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef NX_NODE_DECODER_STATS_EN
    logic sel_ok;
    logic drop;

    assign sel_ok = 32'(ctrl.value[15:8]) < INPUTS / MASK_CHUNK_W;

    always_comb begin
        drop = 1'b0;
        if (accept) begin
            case (cmd)
                CMD_SIGNAL:  drop = !sig_ok;
                CMD_CONTROL: begin
                    case (ctrl.param)
                        PARAM_NUM_INSTR, PARAM_LOAD_RESET: drop = 1'b0;
                        PARAM_LOOPBACK:                    drop = !sel_ok;
                        default:                           drop = 1'b1;
                    endcase
                end
                CMD_RSVD:    drop = 1'b1;
                default:     drop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_drop_count <= '0;
        else if (drop && (o_drop_count != '1))
            o_drop_count <= o_drop_count + 1'b1;
    end
`else
    assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_nx_node_decoder.sv
// Self-checking bench for nx_node_decoder: directed scenarios plus randomized traffic vs a message-level model.
module tb_nx_node_decoder;
    import nx_node_decoder_pkg::*;

    localparam int unsigned INPUTS     = 32;
    localparam int unsigned RAM_ADDR_W = 10;
    localparam int unsigned RAM_DATA_W = 32;
    localparam int unsigned IDX_W      = $clog2(INPUTS);
    localparam int unsigned DEPTH      = 1 << RAM_ADDR_W;
    localparam int unsigned OUT_W      = 3 + RAM_ADDR_W + RAM_DATA_W + INPUTS + IDX_W + 3 + NODE_PARAM_WIDTH + 16;
    localparam int unsigned CTL_W      = 1 + IDX_W + 2 + INPUTS + NODE_PARAM_WIDTH + 16;

    logic                        clk = 1'b0;
    logic                        rst_n;
    node_message_t               msg_data;
    logic                        msg_valid;
    logic                        msg_ready;
    logic                        idle;
    logic [RAM_ADDR_W-1:0]       ram_addr;
    logic [RAM_DATA_W-1:0]       ram_wr_data;
    logic                        ram_wr_en;
    logic                        ram_wr_ready;
    logic [INPUTS-1:0]           loopback_mask;
    logic [IDX_W-1:0]            input_index;
    logic                        input_value;
    logic                        input_is_seq;
    logic                        input_update;
    logic [NODE_PARAM_WIDTH-1:0] num_instr;
    logic [15:0]                 drop_count;

    always #5 clk = ~clk;

    nx_node_decoder #(
        .INPUTS     (INPUTS),
        .RAM_ADDR_W (RAM_ADDR_W),
        .RAM_DATA_W (RAM_DATA_W)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_msg_data      (msg_data),
        .i_msg_valid     (msg_valid),
        .o_msg_ready     (msg_ready),
        .o_idle          (idle),
        .o_ram_addr      (ram_addr),
        .o_ram_wr_data   (ram_wr_data),
        .o_ram_wr_en     (ram_wr_en),
        .i_ram_wr_ready  (ram_wr_ready),
        .o_loopback_mask (loopback_mask),
        .o_input_index   (input_index),
        .o_input_value   (input_value),
        .o_input_is_seq  (input_is_seq),
        .o_input_update  (input_update),
        .o_num_instr     (num_instr),
        .o_drop_count    (drop_count)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];

    logic [OUT_W-1:0] all_out;
    logic [CTL_W-1:0] ctl_out;
    assign all_out = {msg_ready, idle, ram_wr_en, ram_addr, ram_wr_data, loopback_mask,
                      input_index, input_value, input_is_seq, input_update, num_instr, drop_count};
    assign ctl_out = {input_update, input_index, input_value, input_is_seq, loopback_mask, num_instr, drop_count};

    // Record every write the store accepts; ready only changes just after posedge.
    always @(negedge clk)
        if (rst_n && ram_wr_en && ram_wr_ready)
            obs_q.push_back({32'(ram_addr), ram_wr_data});

    // Message-level model state
    int unsigned                 m_ptr;
    bit                          m_half;
    logic [15:0]                 m_low;
    logic [INPUTS-1:0]           m_mask;
    logic [NODE_PARAM_WIDTH-1:0] m_num;
    logic [IDX_W-1:0]            m_idx;
    logic                        m_val, m_seq, m_strobe;
    int unsigned                 m_drop;
    bit                          rand_ready = 1'b0;

    function automatic void model_reset();
        m_ptr = 0; m_half = 0; m_low = '0; m_mask = '0; m_num = '0;
        m_idx = '0; m_val = 0; m_seq = 0; m_strobe = 0; m_drop = 0;
        exp_q.delete();
        obs_q.delete();
    endfunction

    function automatic logic [15:0] exp_drop();
`ifdef NX_NODE_DECODER_STATS_EN
        return (m_drop > 65535) ? 16'hFFFF : 16'(m_drop);
`else
        return 16'h0;
`endif
    endfunction

    function automatic void model_apply(node_message_t m);
        int unsigned sel;
        m_strobe = 0;
        case (m.header.command)
            CMD_LOAD: begin
                if (!m_half) begin
                    m_low  = m.payload.load.data;
                    m_half = 1;
                end else begin
                    exp_q.push_back({32'(m_ptr), m.payload.load.data, m_low});
                    m_ptr  = (m_ptr + 1) % DEPTH;
                    m_half = 0;
                end
            end
            CMD_SIGNAL: begin
                if (int'(m.payload.sig.index) < int'(INPUTS)) begin
                    m_idx    = IDX_W'(m.payload.sig.index);
                    m_val    = m.payload.sig.value;
                    m_seq    = m.payload.sig.is_seq;
                    m_strobe = 1;
                end else m_drop++;
            end
            CMD_CONTROL: begin
                case (m.payload.ctrl.param)
                    3'd0: m_num = m.payload.ctrl.value[NODE_PARAM_WIDTH-1:0];
                    3'd1: begin
                        sel = m.payload.ctrl.value[15:8];
                        if (sel < INPUTS / 8) begin
                            for (int unsigned b = 0; b < 8; b++)
                                m_mask[sel*8 + b] = m.payload.ctrl.value[b];
                        end else m_drop++;
                    end
                    3'd2: begin m_ptr = 0; m_half = 0; end
                    default: m_drop++;
                endcase
            end
            default: m_drop++;
        endcase
    endfunction

    function automatic node_message_t mk_load(logic [15:0] d);
        node_message_t m = '0;
        m.header.command   = CMD_LOAD;
        m.payload.load.data = d;
        return m;
    endfunction

    function automatic node_message_t mk_signal(logic [7:0] idx, logic seq, logic val);
        node_message_t m = '0;
        m.header.command       = CMD_SIGNAL;
        m.payload.sig.index    = idx;
        m.payload.sig.is_seq   = seq;
        m.payload.sig.value    = val;
        return m;
    endfunction

    function automatic node_message_t mk_control(logic [2:0] p, logic [15:0] v);
        node_message_t m = '0;
        m.header.command     = CMD_CONTROL;
        m.payload.ctrl.param = p;
        m.payload.ctrl.value = v;
        return m;
    endfunction

    // Present one message, wait (bounded) for ready, return #1 after the accepting edge.
    task automatic send(input node_message_t m);
        int unsigned n = 0;
        @(negedge clk);
        while (!msg_ready && n < 200) begin
            @(posedge clk); #1;
            if (rand_ready) ram_wr_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (!msg_ready) begin
            compared++; mismatched++;
            $display("FAIL send_timeout: msg_ready=%0b after %0d cycles, required 1", msg_ready, n);
        end else begin
            msg_data  = m;
            msg_valid = 1'b1;
            @(posedge clk); #1;
            msg_valid = 1'b0;
            model_apply(m);
            if (rand_ready) ram_wr_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain();
        int unsigned n = 0;
        ram_wr_ready = 1'b1;
        while (ram_wr_en && n < 50) begin @(posedge clk); #1; n++; end
        compared++;
        if (ram_wr_en !== 1'b0) begin
            mismatched++;
            $display("FAIL drain_timeout: ram_wr_en=%0b, required 0", ram_wr_en);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; msg_valid = 1'b0; msg_data = '0; ram_wr_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        compared++;
        if (all_out !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h, required 0", all_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if ({msg_ready, idle, ram_wr_en} !== 3'b110) begin
            mismatched++;
            $display("FAIL reset_release: ready/idle/wr_en=%b, required 110", {msg_ready, idle, ram_wr_en});
        end
    endtask

    task automatic test_load_pair();
        send(mk_load(16'h1111));
        send(mk_load(16'h2222));
        compared++;
        if ({ram_wr_en, ram_addr, ram_wr_data} !== {1'b1, 10'd0, 32'h2222_1111}) begin
            mismatched++;
            $display("FAIL load_pair_write: en=%0b addr=%0d data=%h, required en=1 addr=0 data=22221111",
                     ram_wr_en, ram_addr, ram_wr_data);
        end
        @(posedge clk); #1;
        compared++;
        if ({ram_wr_en, msg_ready, ram_addr} !== {1'b0, 1'b1, 10'd1} || obs_q.size() != 1) begin
            mismatched++;
            $display("FAIL load_pair_done: en=%0b ready=%0b ptr=%0d writes=%0d, required 0 1 1 1",
                     ram_wr_en, msg_ready, ram_addr, obs_q.size());
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        ram_wr_ready = 1'b0;
        send(mk_load(16'h1111));
        send(mk_load(16'h2222));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if ({ram_wr_en, msg_ready, idle, ram_addr, ram_wr_data} !== {3'b100, 10'd1, 32'h2222_1111}) begin
                mismatched++;
                $display("FAIL backpressure_hold[%0d]: en=%0b ready=%0b idle=%0b addr=%0d data=%h, required 1 0 0 1 22221111",
                         i, ram_wr_en, msg_ready, idle, ram_addr, ram_wr_data);
            end
        end
        @(posedge clk); #1;
        ram_wr_ready = 1'b1;
        @(posedge clk); #1;
        compared++;
        if ({ram_wr_en, msg_ready} !== 2'b01 || obs_q.size() != 1 || obs_q[0] !== {32'd1, 32'h2222_1111}) begin
            mismatched++;
            $display("FAIL backpressure_release: en=%0b ready=%0b writes=%0d, required en=0 ready=1 one write at addr 1",
                     ram_wr_en, msg_ready, obs_q.size());
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_signal();
        send(mk_signal(8'd5, 1'b1, 1'b1));
        compared++;
        if ({input_update, input_index, input_value, input_is_seq} !== {1'b1, 5'd5, 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL signal_strobe: upd=%0b idx=%0d val=%0b seq=%0b, required 1 5 1 1",
                     input_update, input_index, input_value, input_is_seq);
        end
        @(posedge clk); #1;
        compared++;
        if ({input_update, input_index, input_value, input_is_seq} !== {1'b0, 5'd5, 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL signal_hold: upd=%0b idx=%0d val=%0b seq=%0b, required 0 5 1 1",
                     input_update, input_index, input_value, input_is_seq);
        end
        send(mk_signal(8'd40, 1'b0, 1'b0));
        compared++;
        if ({input_update, input_index, input_value, input_is_seq} !== {1'b0, 5'd5, 1'b1, 1'b1} ||
            drop_count !== exp_drop()) begin
            mismatched++;
            $display("FAIL signal_out_of_range: upd=%0b idx=%0d drop=%0d, required upd=0 idx=5 drop=%0d",
                     input_update, input_index, drop_count, exp_drop());
        end
    endtask

    task automatic test_control();
        send(mk_control(3'd1, 16'h02A5));
        send(mk_control(3'd0, 16'h0010));
        compared++;
        if (loopback_mask !== 32'h00A5_0000 || num_instr !== 16'd16) begin
            mismatched++;
            $display("FAIL control_params: mask=%h num_instr=%0d, required 00a50000 16", loopback_mask, num_instr);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] lo, hi;
        int          bad = 0;
        send(mk_control(3'd2, 16'h0000));
        for (int i = 0; i < int'(DEPTH); i++) begin
            send(mk_load(16'($urandom)));
            send(mk_load(16'($urandom)));
        end
        send(mk_load(16'hDEAD));
        send(mk_control(3'd2, 16'h0000));
        lo = 16'($urandom); hi = 16'($urandom);
        send(mk_load(lo));
        send(mk_load(hi));
        drain();
        compared++;
        if (obs_q.size() != DEPTH + 1 || obs_q[DEPTH-1].addr !== 32'(DEPTH-1) ||
            obs_q[DEPTH] !== {32'd0, hi, lo}) begin
            mismatched++;
            $display("FAIL wrap_final: writes=%0d last=%h, required %0d writes ending addr 0 data %h",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[$] : 64'h0, DEPTH + 1, {hi, lo});
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            wr_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            compared++;
            if (o !== e) begin
                mismatched++;
                if (bad++ < 5) $display("FAIL wrap_write: got addr=%0d data=%h, required addr=%0d data=%h",
                                        o.addr, o.data, e.addr, e.data);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        node_message_t m;
        int            bad = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            m = '0;
            m.header.command = node_command_t'(2'($urandom_range(0, 3)));
            case (m.header.command)
                CMD_LOAD:    m.payload.load.data = 16'($urandom);
                CMD_SIGNAL:  m = mk_signal(8'($urandom_range(0, 63)), 1'($urandom), 1'($urandom));
                CMD_CONTROL: begin
                    m = mk_control(3'($urandom_range(0, 7)), 16'($urandom));
                    if (m.payload.ctrl.param == 3'd1) m.payload.ctrl.value[15:8] = 8'($urandom_range(0, 5));
                end
                default:     m.payload = node_payload_t'(19'($urandom));
            endcase
            send(m);
            compared++;
            if (ctl_out !== {m_strobe, m_idx, m_val, m_seq, m_mask, m_num, exp_drop()}) begin
                mismatched++;
                if (bad++ < 5) $display("FAIL random_ctl[%0d]: got %h, required %h", i, ctl_out,
                                        {m_strobe, m_idx, m_val, m_seq, m_mask, m_num, exp_drop()});
            end
        end
        rand_ready = 1'b0;
        drain();
        @(negedge clk);
        compared++;
        if (obs_q.size() != exp_q.size() || idle !== 1'b1) begin
            mismatched++;
            $display("FAIL random_write_count: writes=%0d idle=%0b, required %0d idle=1", obs_q.size(), idle, exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            wr_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            compared++;
            if (o !== e) begin
                mismatched++;
                if (bad++ < 10) $display("FAIL random_write: got addr=%0d data=%h, required addr=%0d data=%h",
                                         o.addr, o.data, e.addr, e.data);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_write();
        ram_wr_ready = 1'b1;
        send(mk_control(3'd2, 16'h0000));
        ram_wr_ready = 1'b0;
        send(mk_load(16'hAAAA));
        send(mk_load(16'h5555));
        compared++;
        if (ram_wr_en !== 1'b1) begin
            mismatched++;
            $display("FAIL midwrite_pending: ram_wr_en=%0b, required 1", ram_wr_en);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (all_out !== '0) begin
            mismatched++;
            $display("FAIL midwrite_reset_outputs: got %h, required 0", all_out);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        ram_wr_ready = 1'b1;
        repeat (4) @(negedge clk);
        compared++;
        if ({ram_wr_en, msg_ready, ram_addr} !== {1'b0, 1'b1, 10'd0} || obs_q.size() != 0) begin
            mismatched++;
            $display("FAIL midwrite_after_release: en=%0b ready=%0b addr=%0d writes=%0d, required 0 1 0 0",
                     ram_wr_en, msg_ready, ram_addr, obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_load_pair();
        test_backpressure();
        test_signal();
        test_control();
        test_wrap();
        test_random();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
